// File: rtl/combat_pkg.sv
// combat_pkg: shared screen/tile geometry, types and tile ROM contents
package combat_pkg;
  localparam int TILE_SZ   = 16;
  localparam int MAP_COLS  = 40;
  localparam int MAP_ROWS  = 30;
  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int IDX_W     = 4;
  localparam int SUB_W     = $clog2(TILE_SZ);
  localparam int MAP_DEPTH = MAP_COLS * MAP_ROWS;
  typedef logic [IDX_W-1:0] pal_idx_t;
  typedef logic [10:0] map_addr_t;
  // Built-in tile art: texel = tile ^ row ^ col ^ 9, so tile 3 texel(0,0) is 4'hA
  function automatic pal_idx_t rom_texel(input logic [IDX_W+7:0] a);
    return a[11:8] ^ a[7:4] ^ a[3:0] ^ 4'h9;
  endfunction
endpackage

// File: rtl/tile_index_fetch_rom.sv
// tile_rom: 4096 x IDX_W synchronous tile texel ROM, one read port
module tile_rom
  import combat_pkg::*;
(
  input  logic             Clk,
  input  logic [IDX_W+7:0] i_addr,
  output pal_idx_t         o_data
);
  always_ff @(posedge Clk) o_data <= rom_texel(i_addr);
endmodule

// File: rtl/tile_index_fetch.sv
// tile_index_fetch: 3-stage DrawX/DrawY -> tile map -> tile ROM palette index pipeline
module tile_index_fetch
  import combat_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic      de,
  input  logic      map_we,
  input  map_addr_t map_waddr,
  input  pal_idx_t  map_wdata,
  output pal_idx_t  index,
  output logic      index_vld,
  output logic [9:0] out_x,
  output logic [9:0] out_y
);
  logic [9-SUB_W:0] w_row, w_col;
  logic [11:0]      w_lin;
  map_addr_t        w_addr;
  logic             w_in_rng;
  pal_idx_t         w_texel;
  map_addr_t        r0_addr;
  logic [7:0]       r0_sub, r1_sub;
  logic [9:0]       r0_x, r0_y, r1_x, r1_y, r2_x, r2_y;
  logic             r0_vld, r1_vld, r2_vld;
  pal_idx_t         r1_tile;
  pal_idx_t         r_map [MAP_DEPTH];
  assign w_row    = DrawY[9:SUB_W];
  assign w_col    = DrawX[9:SUB_W];
  // row*40 as (row<<5)+(row<<3); off-map addresses clamp to 0 and are masked later
  assign w_lin    = (12'(w_row) << 5) + (12'(w_row) << 3) + 12'(w_col);
  assign w_addr   = (w_lin < 12'(MAP_DEPTH)) ? w_lin[10:0] : '0;
  assign w_in_rng = de && (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r0_addr <= '0;
      r0_sub  <= '0;
      r0_x    <= '0;
      r0_y    <= '0;
      r0_vld  <= 1'b0;
      r1_sub  <= '0;
      r1_x    <= '0;
      r1_y    <= '0;
      r1_vld  <= 1'b0;
      r2_x    <= '0;
      r2_y    <= '0;
      r2_vld  <= 1'b0;
    end else begin
      r0_addr <= w_addr;
      r0_sub  <= {DrawY[3:0], DrawX[3:0]};
      r0_x    <= DrawX;
      r0_y    <= DrawY;
      r0_vld  <= w_in_rng;
      r1_sub  <= r0_sub;
      r1_x    <= r0_x;
      r1_y    <= r0_y;
      r1_vld  <= r0_vld;
      r2_x    <= r1_x;
      r2_y    <= r1_y;
      r2_vld  <= r1_vld;
    end
  end
  // Read-before-write: a same-address read this edge still sees the old tile id
  always_ff @(posedge Clk) begin
    if (map_we && (map_waddr < 11'(MAP_DEPTH))) r_map[map_waddr] <= map_wdata;
    r1_tile <= r_map[r0_addr];
  end
  tile_rom u_rom (
    .Clk    (Clk),
    .i_addr ({r1_tile, r1_sub}),
    .o_data (w_texel)
  );
  assign index     = r2_vld ? w_texel : '0;
  assign index_vld = r2_vld;
  assign out_x     = r2_x;
  assign out_y     = r2_y;
endmodule
